// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART types, encodings and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_STICK = 2'b11
  } parity_mode_e;

  typedef enum logic [1:0] {
    WL_5 = 2'b00,
    WL_6 = 2'b01,
    WL_7 = 2'b10,
    WL_8 = 2'b11
  } word_len_e;

  localparam int unsigned WORDLEN_BASE = 5;

  function automatic logic [3:0] data_bits(input logic [1:0] wl);
    return 4'(WORDLEN_BASE) + {2'b00, wl};
  endfunction

  // Parity covers only the active data bits; stick mode takes bit 8 of the FIFO word.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wl,
                                       input logic [1:0] mode, input logic stick);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - wl);
    x    = ^(data & mask);
    case (mode)
      PAR_EVEN:  return x;
      PAR_ODD:   return ~x;
      PAR_STICK: return stick;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - Oversampling tick counter with bit-end strobe
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic bit_end_o
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = tick_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer: FIFO pop, framing and serialisation
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       fifo_empty_i,
  input  logic [8:0] fifo_data_i,
  output logic       fifo_read_o,
  input  logic       baud_tick_i,
  input  logic [1:0] word_len_i,
  input  logic [1:0] parity_mode_i,
  input  logic       two_stop_i,
  input  logic       break_req_i,
  output logic       tx_o,
  output logic       busy_o
);

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] wl_q;
  logic [1:0] par_mode_q;
  logic       two_stop_q;
  logic       parity_q;
  logic       tx_q;
  logic       busy_q;
  logic       read_q;

  logic bit_end;
  logic timer_clear;
  logic last_bit;
  logic can_fetch;

  assign timer_clear = (state_q == IDLE) || (state_q == FETCH) ||
                       (state_q == LOAD) || (state_q == BREAK);
  assign last_bit    = (bit_cnt_q == 3'(data_bits(wl_q) - 4'd1));
  assign can_fetch   = enable_i && !fifo_empty_i && !break_req_i;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear),
    .tick_i   (baud_tick_i),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wl_q       <= '0;
      par_mode_q <= '0;
      two_stop_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (break_req_i) begin
            state_q <= BREAK;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else if (enable_i && !fifo_empty_i) begin
            state_q <= FETCH;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          shift_q    <= fifo_data_i[7:0];
          wl_q       <= word_len_i;
          par_mode_q <= parity_mode_i;
          two_stop_q <= two_stop_i;
          parity_q   <= calc_parity(fifo_data_i[7:0], word_len_i, parity_mode_i, fifo_data_i[8]);
          tx_q       <= 1'b0;
          state_q    <= START;
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (par_mode_q != PAR_NONE) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q   <= STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        STOP: begin
          // bit_cnt_q marks the first of two stop bits as done.
          if (bit_end) begin
            if (two_stop_q && (bit_cnt_q == 3'd0)) begin
              bit_cnt_q <= 3'd1;
            end else if (can_fetch) begin
              state_q <= FETCH;
              read_q  <= 1'b1;
            end else if (break_req_i) begin
              state_q <= BREAK;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        BREAK: begin
          if (!break_req_i) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign fifo_read_o = read_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - Self-checking bench for uart_tx_ctrl with frame-level reference model
module tb_uart_tx_ctrl;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic [8:0] fifo_data_i = '0;
  logic       fifo_read_o;
  logic       baud_tick_i = 1'b0;
  logic [1:0] word_len_i = 2'b11;
  logic [1:0] parity_mode_i = 2'b00;
  logic       two_stop_i = 1'b0;
  logic       break_req_i = 1'b0;
  logic       tx_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_on = 0;
  bit tick_all = 1;

  logic [8:0] fifo_q[$];
  logic       tx_log[$];
  logic       busy_log[$];
  int         read_idx[$];

  int m_phase = 0;  // 0 idle, 1 fetch, 2 load, 3 framing, 4 break
  bit m_tx = 1;
  bit m_rd = 0;
  int m_cnt = 0;
  int m_idx = 0;
  bit m_bits[$];

  uart_tx_ctrl #(.OVERSAMPLE(OS)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_read_o  (fifo_read_o),
    .baud_tick_i  (baud_tick_i),
    .word_len_i   (word_len_i),
    .parity_mode_i(parity_mode_i),
    .two_stop_i   (two_stop_i),
    .break_req_i  (break_req_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a frame is a list of line levels, each held for OS ticks.
  task automatic build_frame();
    int n, ones;
    n = 5 + int'(word_len_i);
    ones = 0;
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      m_bits.push_back(fifo_data_i[i]);
      ones += int'(fifo_data_i[i]);
    end
    case (parity_mode_i)
      2'b01: m_bits.push_back(bit'(ones % 2));
      2'b10: m_bits.push_back(bit'(1 - ones % 2));
      2'b11: m_bits.push_back(fifo_data_i[8]);
      default: ;
    endcase
    m_bits.push_back(1'b1);
    if (two_stop_i) m_bits.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    if (rst_i) begin
      m_phase = 0; m_tx = 1; m_rd = 0;
    end else begin
      case (m_phase)
        0: begin
          if (break_req_i) begin m_phase = 4; m_tx = 0; end
          else if (enable_i && !fifo_empty_i) begin m_phase = 1; m_rd = 1; end
        end
        1: begin m_phase = 2; m_rd = 0; end
        2: begin
          build_frame();
          m_phase = 3; m_cnt = 0; m_idx = 0; m_tx = m_bits[0];
        end
        3: begin
          if (baud_tick_i) begin
            m_cnt++;
            if (m_cnt == OS) begin
              m_cnt = 0;
              m_idx++;
              if (m_idx == m_bits.size()) begin
                if (enable_i && !fifo_empty_i && !break_req_i) begin m_phase = 1; m_rd = 1; m_tx = 1; end
                else if (break_req_i) begin m_phase = 4; m_tx = 0; end
                else begin m_phase = 0; m_tx = 1; end
              end else begin
                m_tx = m_bits[m_idx];
              end
            end
          end
        end
        default: if (!break_req_i) begin m_phase = 0; m_tx = 1; end
      endcase
    end
  end

  always @(negedge clk) begin
    baud_tick_i = tick_all ? 1'b1 : ($urandom_range(0, 3) != 0);
    tx_log.push_back(tx_o);
    busy_log.push_back(busy_o);
    if (cmp_on) begin
      chk("tx", tx_o, m_tx);
      chk("busy", busy_o, logic'(m_phase != 0));
      chk("fifo_read", fifo_read_o, m_rd);
    end
    if (fifo_read_o === 1'b1) begin
      read_idx.push_back(tx_log.size() - 1);
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_when_empty: got read=1 required read=0 at t=%0t", $time);
      end else begin
        fifo_data_i = fifo_q.pop_front();
      end
    end
    fifo_empty_i = (fifo_q.size() == 0);
  end

  task automatic wait_read(input int n, output int r);
    for (int i = 0; i < 5000 && read_idx.size() < n; i++) @(negedge clk);
    chk_int("read_count_wait", read_idx.size() >= n ? n : read_idx.size(), n);
    r = (read_idx.size() >= n) ? read_idx[n-1] : 0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    repeat (3) @(negedge clk);
    for (i = 0; i < limit && (busy_o !== 1'b0 || fifo_q.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("idle_reached", busy_o, 1'b0);
  endtask

  task automatic set_cfg(input logic [1:0] wl, input logic [1:0] pm, input logic ts);
    word_len_i = wl; parity_mode_i = pm; two_stop_i = ts;
  endtask

  function automatic int mid(input int r, input int k);
    return r + 2 + OS * k + OS / 2;
  endfunction

  initial begin
    int r, r2, r3, base;
    logic [9:0] pat;
    logic [8:0] pdata[3];
    logic [1:0] pmode[3];
    logic       pexp[3];

    repeat (3) @(negedge clk);
    chk("reset_tx", tx_o, 1'b1);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_read", fifo_read_o, 1'b0);
    cmp_on = 1;
    rst_i = 0;

    // 0x055, 8N1
    set_cfg(2'b11, 2'b00, 1'b0);
    enable_i = 1;
    fifo_q.push_back(9'h055);
    wait_read(1, r);
    wait_idle(2000);
    pat = 10'b10_1010_1010;
    for (int k = 0; k < 10; k++) chk($sformatf("frame55_bit%0d", k), tx_log[mid(r, k)], pat[k]);
    chk("frame55_busy_last", busy_log[r + 161], 1'b1);
    chk("frame55_busy_fall", busy_log[r + 162], 1'b0);
    chk_int("frame55_reads", read_idx.size(), 1);

    // Parity modes on 0xA3 (four ones)
    pdata[0] = 9'h0A3; pmode[0] = 2'b01; pexp[0] = 1'b0;
    pdata[1] = 9'h0A3; pmode[1] = 2'b10; pexp[1] = 1'b1;
    pdata[2] = 9'h1A3; pmode[2] = 2'b11; pexp[2] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      set_cfg(2'b11, pmode[p], 1'b0);
      base = read_idx.size();
      fifo_q.push_back(pdata[p]);
      wait_read(base + 1, r);
      wait_idle(2000);
      chk($sformatf("parity_mode%0d", pmode[p]), tx_log[mid(r, 9)], pexp[p]);
      chk($sformatf("parity_stop%0d", pmode[p]), tx_log[mid(r, 10)], 1'b1);
    end

    // 5 data bits, two stop bits: 8 bits = 128 ticks
    set_cfg(2'b00, 2'b00, 1'b1);
    base = read_idx.size();
    fifo_q.push_back(9'h01F);
    wait_read(base + 1, r);
    wait_idle(2000);
    chk("w5_start", tx_log[mid(r, 0)], 1'b0);
    chk("w5_bit0", tx_log[mid(r, 1)], 1'b1);
    chk("w5_bit4", tx_log[mid(r, 5)], 1'b1);
    chk("w5_stop2", tx_log[mid(r, 7)], 1'b1);
    chk("w5_busy_last", busy_log[r + 2 + 127], 1'b1);
    chk("w5_busy_fall", busy_log[r + 2 + 128], 1'b0);

    // Three queued words back to back
    set_cfg(2'b11, 2'b00, 1'b0);
    base = read_idx.size();
    fifo_q.push_back(9'h0F0); fifo_q.push_back(9'h033); fifo_q.push_back(9'h0C5);
    wait_read(base + 3, r3);
    r = read_idx[base]; r2 = read_idx[base + 1];
    wait_idle(3000);
    chk_int("b2b_gap1", r2 - r, 162);
    chk_int("b2b_gap2", r3 - r2, 162);
    chk("b2b_load_high", tx_log[r2 + 1], 1'b1);
    chk("b2b_start", tx_log[r2 + 2], 1'b0);
    chk_int("b2b_reads", read_idx.size(), base + 3);

    // Break raised mid-frame
    base = read_idx.size();
    fifo_q.push_back(9'h0AA);
    wait_read(base + 1, r);
    repeat (50) @(negedge clk);
    break_req_i = 1;
    fifo_q.push_back(9'h03C);
    repeat (200) @(negedge clk);
    chk("break_frame_done", tx_log[mid(r, 9)], 1'b1);
    chk("break_tx_low", tx_o, 1'b0);
    chk("break_busy", busy_o, 1'b1);
    chk_int("break_no_pop", read_idx.size(), base + 1);
    break_req_i = 0;
    @(negedge clk);
    chk("break_exit_tx", tx_o, 1'b1);
    chk("break_exit_busy", busy_o, 1'b0);
    wait_read(base + 2, r);
    wait_idle(2000);

    // Reset during data bit 3
    base = read_idx.size();
    fifo_q.push_back(9'h0E7);
    wait_read(base + 1, r);
    for (int i = 0; i < 500 && tx_log.size() <= r + 2 + OS * 4 + 5; i++) @(negedge clk);
    chk("rst_mid_busy_before", busy_o, 1'b1);
    rst_i = 1;
    @(negedge clk);
    chk("rst_mid_tx", tx_o, 1'b1);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_read", fifo_read_o, 1'b0);
    rst_i = 0;
    fifo_q.push_back(9'h05A);
    wait_read(base + 2, r);
    wait_idle(2000);
    chk("rst_resume_bit1", tx_log[mid(r, 2)], 1'b1);

    // Randomised traffic against the model
    tick_all = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      rst_i = ($urandom_range(0, 4999) == 0);
      if (fifo_q.size() < 16 && $urandom_range(0, 99) < 2) fifo_q.push_back(9'($urandom_range(0, 511)));
      if ($urandom_range(0, 49) == 0) word_len_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) parity_mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) two_stop_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 799) == 0) break_req_i = ~break_req_i;
    end
    rst_i = 0; enable_i = 1; break_req_i = 0;
    wait_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
